// File: rtl/ldst_ahb_master.sv
// Load/store AHB-Lite master: combinational address phase from the EX1 request, one tracked
// data phase, byte-lane store alignment, load extraction/extension and error/misalign reporting.
module ldst_ahb_master #(
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned ADDR_W  = 32,
  parameter logic [3:0]  HPROT_V = 4'h3,
  parameter int unsigned WCNT_W  = 8
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [3:0]        req_op,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic [ADDR_W-1:0] ahb_HADDR,
  output logic [1:0]        ahb_HTRANS,
  output logic              ahb_HWRITE,
  output logic [2:0]        ahb_HSIZE,
  output logic [2:0]        ahb_HBURST,
  output logic              ahb_HMASTLOCK,
  output logic [3:0]        ahb_HPROT,
  output logic [DATA_W-1:0] ahb_HWDATA,
  input  logic [DATA_W-1:0] ahb_HRDATA,
  input  logic              ahb_HREADY,
  input  logic              ahb_HRESP,
  output logic              resp_valid,
  output logic [DATA_W-1:0] resp_rdata,
  output logic              resp_err,
  output logic              resp_misalign,
  output logic              stall,
  output logic [WCNT_W-1:0] wait_cnt
);

  localparam int unsigned OFF_W = $clog2(DATA_W / 8);
  localparam bit          IS64  = (DATA_W == 64);

  typedef enum logic [1:0] {S_IDLE, S_DATA, S_ERR2} state_e;

  state_e              state_q, state_d;
  logic [3:0]          op_q, op_d;
  logic [OFF_W-1:0]    off_q, off_d;
  logic [DATA_W-1:0]   hwdata_q, hwdata_d;
  logic                mis_hold_q, mis_hold_d;
  logic                rvalid_q, rvalid_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic                rerr_q, rerr_d;
  logic                rmis_q, rmis_d;
  logic [WCNT_W-1:0]   wcnt_q, wcnt_d;

  logic                op_ok, op_store, aligned;
  logic [2:0]          op_size;
  logic                blocked, issue, accept_xfer, accept_mis;
  logic [DATA_W-1:0]   rd_shift, rd_ext;

  // Keep the low 'bits' bits of v and fill the rest with sbit; bits >= DATA_W keeps v whole.
  function automatic logic [DATA_W-1:0] extend(input logic [DATA_W-1:0] v,
                                               input logic [6:0]        bits,
                                               input logic              sbit);
    logic [DATA_W-1:0] keep;
    keep = (DATA_W'(1) << bits) - DATA_W'(1);
    return sbit ? (v | ~keep) : (v & keep);
  endfunction

  // NOTE: every signal assigned in an always_comb gets a default first, so no latch can be inferred.
  always_comb begin
    op_ok    = 1'b1;
    op_store = 1'b0;
    op_size  = 3'd0;
    aligned  = 1'b1;
    case (req_op)
      4'h1:        op_store = 1'b1;
      4'h2:        begin op_store = 1'b1; op_size = 3'd1; end
      4'h3:        begin op_store = 1'b1; op_size = 3'd2; end
      4'h4:        begin op_store = 1'b1; op_size = 3'd3; op_ok = IS64; end
      4'h9, 4'ha:  op_size = 3'd0;
      4'hb, 4'hc:  op_size = 3'd1;
      4'hd:        op_size = 3'd2;
      4'he:        begin op_size = 3'd3; op_ok = IS64; end
      4'hf:        begin op_size = 3'd2; op_ok = IS64; end
      default:     op_ok = 1'b0;
    endcase
    case (op_size)
      3'd0:    aligned = 1'b1;
      3'd1:    aligned = ~req_addr[0];
      3'd2:    aligned = (req_addr[1:0] == 2'b00);
      default: aligned = (req_addr[2:0] == 3'b000);
    endcase
  end

  // The bus refuses new address phases during the two-cycle ERROR response and while a
  // held misalign response is still waiting for the response register.
  assign blocked     = (state_q == S_ERR2) || (state_q == S_DATA && ahb_HRESP);
  assign req_ready   = ~RST & ahb_HREADY & ~blocked & ~mis_hold_q;
  assign issue       = ~RST & req_valid & op_ok & aligned & ~blocked & ~mis_hold_q;
  assign accept_xfer = issue & req_ready;
  assign accept_mis  = req_valid & req_ready & op_ok & ~aligned;

  assign ahb_HADDR     = req_addr;
  assign ahb_HTRANS    = issue ? 2'b10 : 2'b00;
  assign ahb_HWRITE    = op_store;
  assign ahb_HSIZE     = op_size;
  assign ahb_HBURST    = 3'b000;
  assign ahb_HMASTLOCK = 1'b0;
  assign ahb_HPROT     = HPROT_V;
  assign ahb_HWDATA    = hwdata_q;

  assign rd_shift = ahb_HRDATA >> {off_q, 3'b000};

  always_comb begin
    case (op_q)
      4'h9:    rd_ext = extend(rd_shift, 7'd8,  rd_shift[7]);
      4'ha:    rd_ext = extend(rd_shift, 7'd8,  1'b0);
      4'hb:    rd_ext = extend(rd_shift, 7'd16, rd_shift[15]);
      4'hc:    rd_ext = extend(rd_shift, 7'd16, 1'b0);
      4'hd:    rd_ext = extend(rd_shift, 7'd32, rd_shift[31]);
      4'hf:    rd_ext = extend(rd_shift, 7'd32, 1'b0);
      4'he:    rd_ext = rd_shift;
      default: rd_ext = '0;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    off_d      = off_q;
    hwdata_d   = hwdata_q;
    mis_hold_d = mis_hold_q;
    rvalid_d   = 1'b0;
    rdata_d    = '0;
    rerr_d     = 1'b0;
    rmis_d     = 1'b0;
    wcnt_d     = wcnt_q;

    if (state_q != S_IDLE && !ahb_HREADY && wcnt_q != '1)
      wcnt_d = wcnt_q + WCNT_W'(1);

    if (mis_hold_q) begin
      rvalid_d   = 1'b1;
      rmis_d     = 1'b1;
      mis_hold_d = 1'b0;
    end

    case (state_q)
      S_DATA: begin
        if (ahb_HREADY) begin
          rvalid_d = 1'b1;
          state_d  = S_IDLE;
          if (ahb_HRESP) rerr_d  = 1'b1;
          else           rdata_d = rd_ext;
        end else if (ahb_HRESP) begin
          state_d = S_ERR2;
        end
      end
      S_ERR2: begin
        if (ahb_HREADY) begin
          rvalid_d = 1'b1;
          rerr_d   = 1'b1;
          state_d  = S_IDLE;
        end
      end
      default: ;
    endcase

    if (accept_xfer) begin
      state_d  = S_DATA;
      op_d     = req_op;
      off_d    = req_addr[OFF_W-1:0];
      hwdata_d = req_wdata << {req_addr[OFF_W-1:0], 3'b000};
    end

    // A misalign reject that coincides with a completing data phase waits one cycle.
    if (accept_mis) begin
      if (state_q == S_DATA) begin
        mis_hold_d = 1'b1;
      end else begin
        rvalid_d = 1'b1;
        rmis_d   = 1'b1;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q    <= S_IDLE;
      op_q       <= 4'h0;
      off_q      <= '0;
      hwdata_q   <= '0;
      mis_hold_q <= 1'b0;
      rvalid_q   <= 1'b0;
      rdata_q    <= '0;
      rerr_q     <= 1'b0;
      rmis_q     <= 1'b0;
      wcnt_q     <= '0;
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      off_q      <= off_d;
      hwdata_q   <= hwdata_d;
      mis_hold_q <= mis_hold_d;
      rvalid_q   <= rvalid_d;
      rdata_q    <= rdata_d;
      rerr_q     <= rerr_d;
      rmis_q     <= rmis_d;
      wcnt_q     <= wcnt_d;
    end
  end

  assign resp_valid    = rvalid_q;
  assign resp_rdata    = rdata_q;
  assign resp_err      = rerr_q;
  assign resp_misalign = rmis_q;
  assign stall         = (state_q != S_IDLE) && !ahb_HREADY;
  assign wait_cnt      = wcnt_q;

endmodule

// File: tb/tb_ldst_ahb_master.sv
// Directed bench for ldst_ahb_master: stimulus pushes expected responses into a scoreboard
// queue, an independent monitor pops and compares whenever resp_valid is seen.
module tb_ldst_ahb_master;

  localparam logic [3:0] OP_SB = 4'h1, OP_SH = 4'h2, OP_SW = 4'h3, OP_SD = 4'h4;
  localparam logic [3:0] OP_LB = 4'h9, OP_LBU = 4'ha, OP_LH = 4'hb, OP_LHU = 4'hc, OP_LW = 4'hd;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    logic        mis;
  } exp_t;

  logic        CLK = 1'b0;
  logic        RST;
  logic        req_valid, req_ready;
  logic [3:0]  req_op;
  logic [31:0] req_addr, req_wdata;
  logic [31:0] HADDR, HWDATA, HRDATA;
  logic [1:0]  HTRANS;
  logic        HWRITE, HMASTLOCK, HREADY, HRESP;
  logic [2:0]  HSIZE, HBURST;
  logic [3:0]  HPROT;
  logic        resp_valid, resp_err, resp_misalign, stall;
  logic [31:0] resp_rdata;
  logic [7:0]  wait_cnt;

  exp_t sb[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  ldst_ahb_master #(.DATA_W(32), .ADDR_W(32), .HPROT_V(4'h3), .WCNT_W(8)) dut (
    .CLK(CLK), .RST(RST),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .ahb_HADDR(HADDR), .ahb_HTRANS(HTRANS), .ahb_HWRITE(HWRITE), .ahb_HSIZE(HSIZE),
    .ahb_HBURST(HBURST), .ahb_HMASTLOCK(HMASTLOCK), .ahb_HPROT(HPROT),
    .ahb_HWDATA(HWDATA), .ahb_HRDATA(HRDATA), .ahb_HREADY(HREADY), .ahb_HRESP(HRESP),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
    .resp_misalign(resp_misalign), .stall(stall), .wait_cnt(wait_cnt)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic push(input logic [31:0] d, input logic e, input logic m);
    exp_t x;
    x.rdata = d;
    x.err   = e;
    x.mis   = m;
    sb.push_back(x);
  endtask

  task automatic set_req(input logic [3:0] op, input logic [31:0] addr, input logic [31:0] wd);
    req_valid = 1'b1;
    req_op    = op;
    req_addr  = addr;
    req_wdata = wd;
  endtask

  task automatic clr_req();
    req_valid = 1'b0;
    req_op    = 4'h0;
    req_addr  = '0;
    req_wdata = '0;
  endtask

  task automatic next_cyc();
    @(posedge CLK);
    #1;
  endtask

  always @(negedge CLK) begin
    if (resp_valid === 1'b1) begin
      if (sb.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL resp_unexpected: got resp_valid=1 rdata=0x%0h expected no response", resp_rdata);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("resp_rdata", 64'(resp_rdata), 64'(e.rdata));
        check("resp_err", 64'(resp_err), 64'(e.err));
        check("resp_misalign", 64'(resp_misalign), 64'(e.mis));
      end
    end
  end

  initial begin
    RST = 1'b1; HRDATA = '0; HREADY = 1'b1; HRESP = 1'b0;
    set_req(OP_LW, 32'h100, 32'h0);
    @(negedge CLK);
    check("rst_htrans", 64'(HTRANS), 64'd0);
    check("rst_req_ready", 64'(req_ready), 64'd0);
    check("rst_resp_valid", 64'(resp_valid), 64'd0);
    check("rst_wait_cnt", 64'(wait_cnt), 64'd0);
    check("rst_hwdata", 64'(HWDATA), 64'd0);
    next_cyc(); RST = 1'b0; clr_req();
    next_cyc();

    // SW, SW, LW back-to-back with three wait states on the second store
    set_req(OP_SW, 32'h10, 32'hDEAD_BEEF);
    @(negedge CLK);
    check("sw1_htrans", 64'(HTRANS), 64'd2);
    check("sw1_hwrite", 64'(HWRITE), 64'd1);
    check("sw1_hsize", 64'(HSIZE), 64'd2);
    check("sw1_hprot", 64'(HPROT), 64'h3);
    push(32'h0, 1'b0, 1'b0);
    next_cyc(); set_req(OP_SW, 32'h14, 32'h1122_3344);
    @(negedge CLK);
    check("sw1_hwdata", 64'(HWDATA), 64'hDEAD_BEEF);
    push(32'h0, 1'b0, 1'b0);
    next_cyc(); set_req(OP_LW, 32'h100, 32'h0); HREADY = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge CLK);
      check("sw2_stall", 64'(stall), 64'd1);
      check("sw2_req_ready", 64'(req_ready), 64'd0);
      check("sw2_hwdata", 64'(HWDATA), 64'h1122_3344);
      next_cyc();
    end
    HREADY = 1'b1;
    @(negedge CLK);
    check("lw_stall_clear", 64'(stall), 64'd0);
    check("lw_htrans", 64'(HTRANS), 64'd2);
    check("lw_hsize", 64'(HSIZE), 64'd2);
    push(32'h8000_00F1, 1'b0, 1'b0);
    next_cyc(); clr_req(); HRDATA = 32'h8000_00F1;
    next_cyc();
    @(negedge CLK);
    check("wait_cnt_3", 64'(wait_cnt), 64'd3);

    // Sub-word loads with sign/zero extension, back-to-back
    next_cyc(); set_req(OP_LB, 32'h103, 32'h0);
    @(negedge CLK);
    check("lb_hsize", 64'(HSIZE), 64'd0);
    check("lb_hwrite", 64'(HWRITE), 64'd0);
    push(32'hFFFF_FF8A, 1'b0, 1'b0);
    next_cyc(); set_req(OP_LBU, 32'h103, 32'h0); HRDATA = 32'h8A00_0000;
    @(negedge CLK); push(32'h0000_008A, 1'b0, 1'b0);
    next_cyc(); set_req(OP_LH, 32'h102, 32'h0); HRDATA = 32'h8A00_0000;
    @(negedge CLK); push(32'hFFFF_8001, 1'b0, 1'b0);
    next_cyc(); set_req(OP_LHU, 32'h000, 32'h0); HRDATA = 32'h8001_0000;
    @(negedge CLK); push(32'h0000_F00F, 1'b0, 1'b0);
    next_cyc(); clr_req(); HRDATA = 32'h0000_F00F;
    next_cyc();

    // Stores with lane alignment; unsupported SD on a 32-bit bus issues nothing
    set_req(OP_SH, 32'h102, 32'h0000_1234);
    @(negedge CLK);
    check("sh_htrans", 64'(HTRANS), 64'd2);
    check("sh_hwrite", 64'(HWRITE), 64'd1);
    check("sh_hsize", 64'(HSIZE), 64'd1);
    push(32'h0, 1'b0, 1'b0);
    next_cyc(); set_req(OP_SB, 32'h101, 32'h0000_00AB);
    @(negedge CLK);
    check("sh_hwdata", 64'(HWDATA), 64'h1234_0000);
    push(32'h0, 1'b0, 1'b0);
    next_cyc(); set_req(OP_SD, 32'h0, 32'h5);
    @(negedge CLK);
    check("sb_hwdata", 64'(HWDATA), 64'h0000_AB00);
    check("sd32_htrans", 64'(HTRANS), 64'd0);
    next_cyc(); clr_req();
    next_cyc();

    // Two-cycle ERROR response, then the next request is retried
    set_req(OP_LW, 32'h200, 32'h0);
    @(negedge CLK); push(32'h0, 1'b1, 1'b0);
    next_cyc(); set_req(OP_LW, 32'h204, 32'h0); HRESP = 1'b1; HREADY = 1'b0;
    @(negedge CLK);
    check("err1_htrans", 64'(HTRANS), 64'd0);
    check("err1_req_ready", 64'(req_ready), 64'd0);
    next_cyc(); HREADY = 1'b1;
    @(negedge CLK);
    check("err2_htrans", 64'(HTRANS), 64'd0);
    check("err2_req_ready", 64'(req_ready), 64'd0);
    next_cyc(); HRESP = 1'b0;
    @(negedge CLK);
    check("retry_htrans", 64'(HTRANS), 64'd2);
    check("retry_haddr", 64'(HADDR), 64'h204);
    push(32'h5555_AAAA, 1'b0, 1'b0);
    next_cyc(); clr_req(); HRDATA = 32'h5555_AAAA;
    next_cyc();
    @(negedge CLK);
    check("wait_cnt_4", 64'(wait_cnt), 64'd4);

    // Misaligned rejects: from idle, and coincident with a completing data phase
    next_cyc(); set_req(OP_LH, 32'h101, 32'h0);
    @(negedge CLK);
    check("mis_htrans", 64'(HTRANS), 64'd0);
    check("mis_req_ready", 64'(req_ready), 64'd1);
    push(32'h0, 1'b0, 1'b1);
    next_cyc(); clr_req();
    next_cyc(); set_req(OP_LW, 32'h300, 32'h0);
    @(negedge CLK); push(32'h0000_0042, 1'b0, 1'b0);
    next_cyc(); set_req(OP_SW, 32'h302, 32'h9); HRDATA = 32'h0000_0042;
    @(negedge CLK);
    check("mis2_htrans", 64'(HTRANS), 64'd0);
    check("mis2_req_ready", 64'(req_ready), 64'd1);
    push(32'h0, 1'b0, 1'b1);
    next_cyc(); set_req(OP_LW, 32'h304, 32'h0);
    @(negedge CLK);
    check("hold_req_ready", 64'(req_ready), 64'd0);
    check("hold_htrans", 64'(HTRANS), 64'd0);
    next_cyc();
    @(negedge CLK);
    check("after_hold_htrans", 64'(HTRANS), 64'd2);
    push(32'h0000_0007, 1'b0, 1'b0);
    next_cyc(); clr_req(); HRDATA = 32'h0000_0007;
    next_cyc();

    // Reset asserted while a data phase is open: no response may appear
    set_req(OP_LW, 32'h400, 32'h0);
    @(negedge CLK);
    check("pre_rst_htrans", 64'(HTRANS), 64'd2);
    next_cyc(); set_req(OP_LW, 32'h404, 32'h0); RST = 1'b1;
    @(negedge CLK);
    check("midrst_htrans", 64'(HTRANS), 64'd0);
    check("midrst_resp_valid", 64'(resp_valid), 64'd0);
    next_cyc(); RST = 1'b0; clr_req();
    for (int i = 0; i < 3; i++) begin
      @(negedge CLK);
      check("postrst_resp_valid", 64'(resp_valid), 64'd0);
      next_cyc();
    end

    check("sb_drained", 64'(sb.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
